// File: rtl/clp_out_writeback_pkg.sv
// Shared types and default sizing for the CLP output writeback stage.
// The state encoding is exported so the layer controller can decode it.
package clp_out_writeback_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } wb_state_e;

    localparam int TM_DEF            = 4;
    localparam int FEATURE_WIDTH_DEF = 8;
    localparam int ADDR_WIDTH_DEF    = 15;
    localparam int FIFO_DEPTH_DEF    = 4;
    localparam int VEC_CNT_W         = 16;

endpackage

// File: rtl/clp_out_writeback_wb_vec_fifo.sv
// Small synchronous FIFO holding whole CLP result vectors.
// The head entry is readable combinationally so the serializer can load it on the pop edge.
module wb_vec_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W:0]   r_wr_ptr;
    logic [PTR_W:0]   r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                       (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_data    = r_mem[r_rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[PTR_W-1:0]] <= i_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/clp_out_writeback.sv
// Buffers CLP result vectors and serializes them as 2-feature words into one of
// two ping-pong output feature memories, one word per cycle.
module clp_out_writeback
    import clp_out_writeback_pkg::*;
#(
    parameter int TM            = TM_DEF,
    parameter int FEATURE_WIDTH = FEATURE_WIDTH_DEF,
    parameter int ADDR_WIDTH    = ADDR_WIDTH_DEF,
    parameter int FIFO_DEPTH    = FIFO_DEPTH_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [ADDR_WIDTH-1:0]         base_addr,
    input  logic [VEC_CNT_W-1:0]          vec_count,
    input  logic                          out_select,
    input  logic                          clp_valid,
    input  logic [TM*FEATURE_WIDTH-1:0]   clp_data,
    output logic                          wr_en_0,
    output logic [ADDR_WIDTH-1:0]         wr_addr_0,
    output logic [2*FEATURE_WIDTH-1:0]    wr_data_0,
    output logic                          wr_en_1,
    output logic [ADDR_WIDTH-1:0]         wr_addr_1,
    output logic [2*FEATURE_WIDTH-1:0]    wr_data_1,
    output logic                          busy,
    output logic                          done,
    output logic                          overflow
);
    localparam int VEC_W  = TM * FEATURE_WIDTH;
    localparam int WORD_W = 2 * FEATURE_WIDTH;
    localparam int WPV    = TM / 2;
    localparam int IDX_W  = (WPV > 1) ? $clog2(WPV) : 1;

    wb_state_e             r_state;
    wb_state_e             w_state_next;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [VEC_CNT_W-1:0]  r_vec_total;
    logic [VEC_CNT_W-1:0]  r_vec_done_cnt;
    logic [VEC_CNT_W-1:0]  r_push_cnt;
    logic                  r_sel;
    logic                  r_overflow;
    logic [VEC_W-1:0]      r_ser_data;
    logic                  r_ser_valid;
    logic [IDX_W-1:0]      r_ser_idx;

    logic                  w_start_acc;
    logic                  w_run;
    logic                  w_push_req;
    logic                  w_ser_last;
    logic                  w_pop;
    logic                  w_drop;
    logic                  w_wr;
    logic                  w_vec_written;
    logic                  w_final;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic [VEC_W-1:0]      w_fifo_data;

    assign w_start_acc   = start && (r_state == ST_IDLE);
    assign w_run         = (r_state == ST_RUN);
    // Pushes are capped at the layer's vector count so stray vectors never reach memory.
    assign w_push_req    = clp_valid && w_run && (r_push_cnt != r_vec_total);
    assign w_ser_last    = r_ser_valid && (r_ser_idx == IDX_W'(WPV - 1));
    assign w_pop         = w_run && !w_fifo_empty && (!r_ser_valid || w_ser_last);
    assign w_drop        = w_push_req && w_fifo_full && !w_pop;
    assign w_wr          = w_run && r_ser_valid;
    assign w_vec_written = w_run && w_ser_last;
    assign w_final       = w_vec_written && (r_vec_done_cnt == r_vec_total - VEC_CNT_W'(1));
    assign overflow      = r_overflow;

    wb_vec_fifo #(
        .WIDTH (VEC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_flush (w_start_acc),
        .i_push  (w_push_req),
        .i_data  (clp_data),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) w_state_next = ST_RUN;
            end
            ST_RUN: begin
                busy = 1'b1;
                if ((r_vec_total == '0) || w_final) w_state_next = ST_DONE;
            end
            ST_DONE: begin
                done         = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Unselected port stays fully at zero so the idle memory sees no address activity.
    always_comb begin
        wr_en_0   = 1'b0;
        wr_addr_0 = '0;
        wr_data_0 = '0;
        wr_en_1   = 1'b0;
        wr_addr_1 = '0;
        wr_data_1 = '0;
        if (w_wr) begin
            if (r_sel) begin
                wr_en_1   = 1'b1;
                wr_addr_1 = r_addr;
                wr_data_1 = r_ser_data[WORD_W-1:0];
            end else begin
                wr_en_0   = 1'b1;
                wr_addr_0 = r_addr;
                wr_data_0 = r_ser_data[WORD_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr         <= '0;
            r_vec_total    <= '0;
            r_vec_done_cnt <= '0;
            r_push_cnt     <= '0;
            r_sel          <= 1'b0;
            r_overflow     <= 1'b0;
        end else if (w_start_acc) begin
            r_addr         <= base_addr;
            r_vec_total    <= vec_count;
            r_vec_done_cnt <= '0;
            r_push_cnt     <= '0;
            r_sel          <= out_select;
            r_overflow     <= 1'b0;
        end else begin
            if (w_wr)          r_addr         <= r_addr + ADDR_WIDTH'(1);
            if (w_vec_written) r_vec_done_cnt <= r_vec_done_cnt + VEC_CNT_W'(1);
            if (w_push_req && !w_drop) r_push_cnt <= r_push_cnt + VEC_CNT_W'(1);
            if (w_drop)        r_overflow     <= 1'b1;
        end
    end

    // Loading on the last word of the current vector keeps back-to-back vectors bubble-free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ser_data  <= '0;
            r_ser_valid <= 1'b0;
            r_ser_idx   <= '0;
        end else if (w_start_acc) begin
            r_ser_valid <= 1'b0;
            r_ser_idx   <= '0;
        end else if (w_pop) begin
            r_ser_data  <= w_fifo_data;
            r_ser_valid <= 1'b1;
            r_ser_idx   <= '0;
        end else if (w_wr) begin
            if (w_ser_last) begin
                r_ser_valid <= 1'b0;
            end else begin
                r_ser_data <= r_ser_data >> WORD_W;
                r_ser_idx  <= r_ser_idx + IDX_W'(1);
            end
        end
    end

endmodule
